// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder with a valid/ready handshake on both sides.
// Operands are captured on the accepting edge, summed LSB-first over WIDTH
// cycles, and the result is held until the consumer takes it.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add the 'op' input
// (0 = add, 1 = subtract as x + ~y + 1). Without it the block only adds.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an operand pair, in_ready = 1
// RUN   | one result bit per cycle, WIDTH cycles total
// DONE  | s/c hold the result, out_valid = 1 until out_ready
`timescale 1ns/1ps

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic [WIDTH-1:0] y_cap;
  logic             carry_init;
  logic             ha1_s;
  logic             ha1_c;
  logic             ha2_s;
  logic             ha2_c;
  logic             carry_nxt;

  // Subtraction reuses the adder: invert y on capture and seed the carry with 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign y_cap      = op ? ~y : y;
  assign carry_init = op;
`else
  assign y_cap      = y;
  assign carry_init = 1'b0;
`endif

  assign accept    = (state == IDLE) && in_valid;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign s         = sum_reg;
  assign c         = carry;

  // One full-adder slice built from two cascaded half adders.
  always_comb begin
    ha1_s     = a_reg[0] ^ b_reg[0];
    ha1_c     = a_reg[0] & b_reg[0];
    ha2_s     = ha1_s ^ carry;
    ha2_c     = ha1_s & carry;
    carry_nxt = ha1_c | ha2_c;
  end

  // Next-state decode; RUN leaves on the edge that processes the last bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = RUN;
      RUN:     if (cnt == LAST_BIT) state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture and the serial datapath; sum bits enter at the MSB so the
  // register is right-aligned after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_reg   <= x;
      b_reg   <= y_cap;
      sum_reg <= '0;
      carry   <= carry_init;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_reg   <= a_reg >> 1;
      b_reg   <= b_reg >> 1;
      sum_reg <= {ha2_s, sum_reg[WIDTH-1:1]};
      carry   <= carry_nxt;
      cnt     <= cnt + CW'(1);
    end
  end

endmodule
